// File: rtl/spi_feeder_pkg.sv
// Shared types and helpers for the SPI transmit packet feeder.
package spi_feeder_pkg;

  localparam int unsigned PKT_BYTES = 16;
  localparam int unsigned PKT_BITS  = 128;

  typedef logic [PKT_BITS-1:0] pkt_t;

  // Packet made of one byte value repeated across all byte lanes.
  function automatic pkt_t idle_pkt(input logic [7:0] fill_byte);
    return {PKT_BYTES{fill_byte}};
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Resynchronises a toggle-encoded request from a foreign clock domain and
// turns every level change into a single-cycle req_o pulse. The first valid
// synchronised sample after reset only sets the reference level.
module toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle_i,
  output logic req_o
);

  logic       s1_q, s2_q, ref_q, primed_q, req_q;
  logic [1:0] vld_q;  // tracks when s1_q / s2_q hold real samples

  // Two-flop synchroniser, priming and registered edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      vld_q    <= 2'b00;
      ref_q    <= 1'b0;
      primed_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      s1_q  <= toggle_i;
      s2_q  <= s1_q;
      vld_q <= {vld_q[0], 1'b1};
      req_q <= 1'b0;
      if (vld_q[1]) begin
        if (!primed_q) begin
          ref_q    <= s2_q;
          primed_q <= 1'b1;
        end else if (s2_q != ref_q) begin
          ref_q <= s2_q;
          req_q <= 1'b1;
        end
      end
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/spi_tx_feeder.sv
// Packs an incoming byte stream into 128-bit packets held in a two-slot
// ping-pong buffer and hands one packet to the SPI transmitter per toggle of
// TxGetNext. Requests that find no full slot get an idle packet and are counted.
// Optional feature: define SPI_FEEDER_FLUSH_EN to pad and release a partial
// packet after FLUSH_CYCLES idle cycles.
module spi_tx_feeder
  import spi_feeder_pkg::*;
#(
  parameter logic [7:0]  IDLE_BYTE    = 8'hA6,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int unsigned FLUSH_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   DataIn,
  input  logic         DataInValid,
  output logic         DataInReady,
  input  logic         TxGetNext,
  output logic [127:0] Tx_packet,
  output logic         PktReady,
  output logic [15:0]  UnderrunCount
);

  pkt_t        slot_q [2];
  pkt_t        slot_d [2];
  logic [1:0]  full_q, full_d;
  logic        wp_q, wp_d, rp_q, rp_d;
  logic [3:0]  fill_q, fill_d;
  pkt_t        tx_q, tx_d;
  logic [15:0] underrun_q, underrun_d;
  logic        req, accept, flush, complete;

  toggle_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .toggle_i (TxGetNext),
    .req_o    (req)
  );

  assign accept = DataInValid && !full_q[wp_q];

`ifdef SPI_FEEDER_FLUSH_EN
  localparam logic [15:0] FlushLast = 16'(FLUSH_CYCLES - 1);

  logic [15:0] timer_q, timer_d;

  // Idle timer: runs only while a partial packet sits without new bytes.
  always_comb begin
    timer_d = timer_q;
    flush   = 1'b0;
    if (accept || (fill_q == 4'd0)) begin
      timer_d = 16'd0;
    end else if (timer_q == FlushLast) begin
      flush   = 1'b1;
      timer_d = 16'd0;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= 16'd0;
    else        timer_q <= timer_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{PAD_BYTE, FLUSH_CYCLES[15:0]};
  assign flush      = 1'b0;
`endif

  assign complete = (accept && (fill_q == 4'd15)) || flush;

  // Slot fill, slot completion and request servicing. Requests look only at
  // the registered full flags, so a slot completing this cycle is not bypassed.
  always_comb begin
    slot_d     = slot_q;
    full_d     = full_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    fill_d     = fill_q;
    tx_d       = tx_q;
    underrun_d = underrun_q;

    if (accept) begin
      // First byte of a packet lands in the top lane; 15 - fill == ~fill.
      slot_d[wp_q][{~fill_q, 3'b000} +: 8] = DataIn;
      fill_d = fill_q + 4'd1;
    end

    if (flush) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= int'(fill_q)) slot_d[wp_q][8*(15-i) +: 8] = PAD_BYTE;
      end
    end

    if (complete) begin
      full_d[wp_q] = 1'b1;
      wp_d         = ~wp_q;
      fill_d       = 4'd0;
    end

    // A full rp slot can never be the slot completing this cycle.
    if (req) begin
      if (full_q[rp_q]) begin
        tx_d         = slot_q[rp_q];
        full_d[rp_q] = 1'b0;
        rp_d         = ~rp_q;
      end else begin
        tx_d = idle_pkt(IDLE_BYTE);
        if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
      end
    end
  end

  // Buffer, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      full_q     <= 2'b00;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      fill_q     <= 4'd0;
      tx_q       <= idle_pkt(IDLE_BYTE);
      underrun_q <= 16'd0;
    end else begin
      slot_q     <= slot_d;
      full_q     <= full_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      fill_q     <= fill_d;
      tx_q       <= tx_d;
      underrun_q <= underrun_d;
    end
  end

  assign DataInReady   = !full_q[wp_q];
  assign PktReady      = |full_q;
  assign Tx_packet     = tx_q;
  assign UnderrunCount = underrun_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed self-checking bench for spi_tx_feeder (FLUSH_CYCLES = 16).
module tb_spi_tx_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [7:0]   DataIn = 8'h00;
  logic         DataInValid = 1'b0;
  logic         DataInReady;
  logic         TxGetNext = 1'b0;
  logic [127:0] Tx_packet;
  logic         PktReady;
  logic [15:0]  UnderrunCount;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] IdlePkt = {16{8'hA6}};

  always #5 clk = ~clk;

  spi_tx_feeder #(
    .IDLE_BYTE    (8'hA6),
    .PAD_BYTE     (8'h00),
    .FLUSH_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .DataIn        (DataIn),
    .DataInValid   (DataInValid),
    .DataInReady   (DataInReady),
    .TxGetNext     (TxGetNext),
    .Tx_packet     (Tx_packet),
    .PktReady      (PktReady),
    .UnderrunCount (UnderrunCount)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    DataIn      = b;
    DataInValid = 1'b1;
    tick(1);
    DataInValid = 1'b0;
  endtask

  // Packet of 16 consecutive byte values starting at 'first', first byte on top.
  function automatic logic [127:0] seq_pkt(input logic [7:0] first);
    logic [127:0] p;
    for (int i = 0; i < 16; i++) p[8*(15-i) +: 8] = first + 8'(i);
    return p;
  endfunction

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick(2);
    checks++; if (Tx_packet !== IdlePkt) begin failures++;
      $display("FAIL reset_tx got=%h want=%h", Tx_packet, IdlePkt); end
    checks++; if (DataInReady !== 1'b1) begin failures++;
      $display("FAIL reset_ready got=%b want=1", DataInReady); end
    checks++; if (PktReady !== 1'b0) begin failures++;
      $display("FAIL reset_pktready got=%b want=0", PktReady); end
    checks++; if (UnderrunCount !== 16'd0) begin failures++;
      $display("FAIL reset_underrun got=%0d want=0", UnderrunCount); end
    rst_n = 1'b1;
    tick(5);
    for (int k = 0; k < 3; k++) begin
      TxGetNext = ~TxGetNext;
      tick(6);
      checks++; if (Tx_packet !== IdlePkt) begin failures++;
        $display("FAIL idle_req%0d got=%h want=%h", k, Tx_packet, IdlePkt); end
    end
    checks++; if (UnderrunCount !== 16'd3) begin failures++;
      $display("FAIL idle_underrun got=%0d want=3", UnderrunCount); end
  endtask

  task automatic test_single_packet;
    int lat;
    logic [127:0] want;
    want = seq_pkt(8'h00);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    checks++; if (PktReady !== 1'b1) begin failures++;
      $display("FAIL single_pktready got=%b want=1", PktReady); end
    TxGetNext = ~TxGetNext;
    lat = 0;
    while (Tx_packet === IdlePkt && lat < 8) begin
      tick(1);
      lat++;
    end
    checks++; if (lat < 3 || lat > 5) begin failures++;
      $display("FAIL single_latency got=%0d want=3..5", lat); end
    checks++; if (Tx_packet !== want) begin failures++;
      $display("FAIL single_pkt got=%h want=%h", Tx_packet, want); end
    checks++; if (PktReady !== 1'b0) begin failures++;
      $display("FAIL single_pktready_fall got=%b want=0", PktReady); end
    checks++; if (UnderrunCount !== 16'd3) begin failures++;
      $display("FAIL single_underrun got=%0d want=3", UnderrunCount); end
    tick(2);
  endtask

  task automatic test_back_pressure;
    int acc;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      DataIn      = 8'(k + 1);
      DataInValid = 1'b1;
      if (DataInReady === 1'b1) acc++;
      tick(1);
    end
    DataInValid = 1'b0;
    checks++; if (acc != 32) begin failures++;
      $display("FAIL bp_accepted got=%0d want=32", acc); end
    checks++; if (DataInReady !== 1'b0) begin failures++;
      $display("FAIL bp_ready_low got=%b want=0", DataInReady); end
    TxGetNext = ~TxGetNext;
    tick(3);
    checks++; if (DataInReady !== 1'b0) begin failures++;
      $display("FAIL bp_ready_early got=%b want=0", DataInReady); end
    tick(1);
    checks++; if (DataInReady !== 1'b1) begin failures++;
      $display("FAIL bp_ready_rise got=%b want=1", DataInReady); end
    checks++; if (Tx_packet !== seq_pkt(8'h01)) begin failures++;
      $display("FAIL bp_pkt1 got=%h want=%h", Tx_packet, seq_pkt(8'h01)); end
    tick(2);
    TxGetNext = ~TxGetNext;
    tick(6);
    checks++; if (Tx_packet !== seq_pkt(8'h11)) begin failures++;
      $display("FAIL bp_pkt2 got=%h want=%h", Tx_packet, seq_pkt(8'h11)); end
    checks++; if (PktReady !== 1'b0 || UnderrunCount !== 16'd3) begin failures++;
      $display("FAIL bp_final got=%b/%0d want=0/3", PktReady, UnderrunCount); end
  endtask

  task automatic test_same_cycle;
    for (int i = 0; i < 15; i++) send_byte(8'h20 + 8'(i));
    TxGetNext = ~TxGetNext;
    tick(3);
    // The 16th byte lands on the edge that services the request.
    send_byte(8'h2F);
    checks++; if (Tx_packet !== IdlePkt) begin failures++;
      $display("FAIL same_idle got=%h want=%h", Tx_packet, IdlePkt); end
    checks++; if (UnderrunCount !== 16'd4) begin failures++;
      $display("FAIL same_underrun got=%0d want=4", UnderrunCount); end
    checks++; if (PktReady !== 1'b1) begin failures++;
      $display("FAIL same_pktready got=%b want=1", PktReady); end
    tick(2);
    TxGetNext = ~TxGetNext;
    tick(6);
    checks++; if (Tx_packet !== seq_pkt(8'h20)) begin failures++;
      $display("FAIL same_next got=%h want=%h", Tx_packet, seq_pkt(8'h20)); end
  endtask

  task automatic test_flush;
    logic [127:0] want;
    want = {8'hAA, 8'hBB, 112'h0};
    send_byte(8'hAA);
    send_byte(8'hBB);
`ifdef SPI_FEEDER_FLUSH_EN
    tick(15);
    checks++; if (PktReady !== 1'b0) begin failures++;
      $display("FAIL flush_early got=%b want=0", PktReady); end
    tick(1);
    checks++; if (PktReady !== 1'b1) begin failures++;
      $display("FAIL flush_pktready got=%b want=1", PktReady); end
    TxGetNext = ~TxGetNext;
    tick(6);
    checks++; if (Tx_packet !== want) begin failures++;
      $display("FAIL flush_pkt got=%h want=%h", Tx_packet, want); end
    checks++; if (UnderrunCount !== 16'd4) begin failures++;
      $display("FAIL flush_underrun got=%0d want=4", UnderrunCount); end
`else
    tick(40);
    checks++; if (PktReady !== 1'b0) begin failures++;
      $display("FAIL noflush_pktready got=%b want=0 (partial %h)", PktReady, want); end
    TxGetNext = ~TxGetNext;
    tick(6);
    checks++; if (Tx_packet !== IdlePkt) begin failures++;
      $display("FAIL noflush_pkt got=%h want=%h", Tx_packet, IdlePkt); end
    checks++; if (UnderrunCount !== 16'd5) begin failures++;
      $display("FAIL noflush_underrun got=%0d want=5", UnderrunCount); end
`endif
  endtask

  task automatic test_reset_mid_packet;
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    rst_n = 1'b0;
    tick(1);
    checks++; if (UnderrunCount !== 16'd0 || Tx_packet !== IdlePkt) begin failures++;
      $display("FAIL mid_reset got=%0d/%h want=0/%h", UnderrunCount, Tx_packet, IdlePkt); end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    checks++; if (PktReady !== 1'b1) begin failures++;
      $display("FAIL mid_pktready got=%b want=1", PktReady); end
    TxGetNext = ~TxGetNext;
    tick(6);
    checks++; if (Tx_packet !== seq_pkt(8'h10)) begin failures++;
      $display("FAIL mid_pkt got=%h want=%h", Tx_packet, seq_pkt(8'h10)); end
    checks++; if (UnderrunCount !== 16'd0 || PktReady !== 1'b0) begin failures++;
      $display("FAIL mid_final got=%0d/%b want=0/0", UnderrunCount, PktReady); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_packet();
    test_back_pressure();
    test_same_cycle();
    test_flush();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
